// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcodes, FSM states, requester ids.
// Optional build macro used by the top: ALU_ARB_FIXED_PRIO_EN (fixed priority to requester 0).
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_RSUB = 3'b010;
  localparam logic [2:0] OP_XNOR = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_ANDN = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational W-bit ALU: add/subtract with carry-borrow and signed overflow, plus bitwise ops.
module alu_arbiter_alu
  import alu_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [2:0]   op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] out_o,
  output logic         co_o,
  output logic         ovf_o,
  output logic         z_o,
  output logic         n_o
);

  logic [W:0] wide;
  logic       ovf;

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    wide = '0;
    ovf  = 1'b0;
    unique case (op_i)
      OP_ADD: begin
        wide = {1'b0, a_i} + {1'b0, b_i};
        ovf  = (a_i[W-1] == b_i[W-1]) && (wide[W-1] != a_i[W-1]);
      end
      OP_SUB: begin
        wide = {1'b0, a_i} - {1'b0, b_i};
        ovf  = (a_i[W-1] != b_i[W-1]) && (wide[W-1] != a_i[W-1]);
      end
      OP_RSUB: begin
        wide = {1'b0, b_i} - {1'b0, a_i};
        ovf  = (b_i[W-1] != a_i[W-1]) && (wide[W-1] != b_i[W-1]);
      end
      OP_XNOR: wide = {1'b0, ~(a_i ^ b_i)};
      OP_AND:  wide = {1'b0, a_i & b_i};
      OP_OR:   wide = {1'b0, a_i | b_i};
      OP_XOR:  wide = {1'b0, a_i ^ b_i};
      OP_ANDN: wide = {1'b0, a_i & ~b_i};
    endcase
  end

  // Bitwise ops leave wide[W] at 0, so the carry flag falls out naturally.
  assign out_o = wide[W-1:0];
  assign co_o  = wide[W];
  assign ovf_o = ovf;
  assign z_o   = (wide[W-1:0] == '0);
  assign n_o   = wide[W-1];

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared ALU; registered, id-tagged response channel.
// Build macro ALU_ARB_FIXED_PRIO_EN: req0 always wins ties (default build: round-robin).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [2:0]   req0_op,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [2:0]   req1_op,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_out,
  output logic         rsp_co,
  output logic         rsp_ovf,
  output logic         rsp_z,
  output logic         rsp_n
);

  state_e       state_q, state_d;
  logic         grant;
  logic         accept;
  logic         grant_q, grant_d;
  logic [2:0]   op_q, op_d;
  logic [W-1:0] a_q, a_d, b_q, b_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
  logic         last_grant_q, last_grant_d;
`endif

  logic         rsp_valid_q, rsp_valid_d;
  logic         rsp_id_q, rsp_id_d;
  logic [W-1:0] rsp_out_q, rsp_out_d;
  logic         rsp_co_q, rsp_co_d, rsp_ovf_q, rsp_ovf_d;
  logic         rsp_z_q, rsp_z_d, rsp_n_q, rsp_n_d;

  logic [W-1:0] alu_out;
  logic         alu_co, alu_ovf, alu_z, alu_n;

  alu_arbiter_alu #(.W(W)) u_alu (
    .op_i  (op_q),
    .a_i   (a_q),
    .b_i   (b_q),
    .out_o (alu_out),
    .co_o  (alu_co),
    .ovf_o (alu_ovf),
    .z_o   (alu_z),
    .n_o   (alu_n)
  );

  always_comb begin
`ifdef ALU_ARB_FIXED_PRIO_EN
    grant = req0_valid ? REQ0 : REQ1;
`else
    if (req0_valid && req1_valid) grant = ~last_grant_q;
    else                          grant = req0_valid ? REQ0 : REQ1;
`endif
  end

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    grant_d     = grant_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
    last_grant_d = last_grant_q;
`endif
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_out_d   = rsp_out_q;
    rsp_co_d    = rsp_co_q;
    rsp_ovf_d   = rsp_ovf_q;
    rsp_z_d     = rsp_z_q;
    rsp_n_d     = rsp_n_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req0_valid || req1_valid) begin
          accept     = 1'b1;
          req0_ready = (grant == REQ0);
          req1_ready = (grant == REQ1);
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = grant_q;
        rsp_out_d   = alu_out;
        rsp_co_d    = alu_co;
        rsp_ovf_d   = alu_ovf;
        rsp_z_d     = alu_z;
        rsp_n_d     = alu_n;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        // Payload stays in place after the handshake; only valid drops.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      grant_d = grant;
      op_d    = (grant == REQ1) ? req1_op : req0_op;
      a_d     = (grant == REQ1) ? req1_a  : req0_a;
      b_d     = (grant == REQ1) ? req1_b  : req0_b;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_grant_d = grant;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= REQ0;
      op_q        <= OP_ADD;
      a_q         <= '0;
      b_q         <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_grant_q <= REQ1;
`endif
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_out_q   <= '0;
      rsp_co_q    <= 1'b0;
      rsp_ovf_q   <= 1'b0;
      rsp_z_q     <= 1'b0;
      rsp_n_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_grant_q <= last_grant_d;
`endif
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_out_q   <= rsp_out_d;
      rsp_co_q    <= rsp_co_d;
      rsp_ovf_q   <= rsp_ovf_d;
      rsp_z_q     <= rsp_z_d;
      rsp_n_q     <= rsp_n_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_out   = rsp_out_q;
  assign rsp_co    = rsp_co_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign rsp_z     = rsp_z_q;
  assign rsp_n     = rsp_n_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: cycle-level protocol model plus arithmetic reference ALU.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int W = 4;

  typedef struct packed {
    logic         id;
    logic [W-1:0] out;
    logic         co;
    logic         ovf;
    logic         z;
    logic         n;
  } rsp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [2:0]   req0_op = '0, req1_op = '0;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         rsp_valid, rsp_ready = 1'b0;
  logic         rsp_id, rsp_co, rsp_ovf, rsp_z, rsp_n;
  logic [W-1:0] rsp_out;

  always #5 clk = ~clk;

  alu_arbiter #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_out    (rsp_out),
    .rsp_co     (rsp_co),
    .rsp_ovf    (rsp_ovf),
    .rsp_z      (rsp_z),
    .rsp_n      (rsp_n)
  );

  int   errors = 0;
  int   checks = 0;

  // Protocol model: 0 = idle, 1 = executing, 2 = response presented.
  int   phase = 0;
  logic last_g = 1'b1;
  logic acc0 = 1'b0, acc1 = 1'b0;
  rsp_t exp_rsp = '0;
  rsp_t last_seen = '0;
  logic grant_log[$];

  function automatic rsp_t ref_alu(input logic id, input logic [2:0] op,
                                   input logic [W-1:0] a, input logic [W-1:0] b);
    int   ia, ib, sa, sb, r, sr;
    rsp_t t;
    ia = int'(a);
    ib = int'(b);
    sa = a[W-1] ? ia - (1 << W) : ia;
    sb = b[W-1] ? ib - (1 << W) : ib;
    r  = 0;
    sr = 0;
    t  = '0;
    t.id = id;
    case (op)
      3'd0: begin r = ia + ib; sr = sa + sb; end
      3'd1: begin r = ia - ib; sr = sa - sb; end
      3'd2: begin r = ib - ia; sr = sb - sa; end
      3'd3: t.out = ~(a ^ b);
      3'd4: t.out = a & b;
      3'd5: t.out = a | b;
      3'd6: t.out = a ^ b;
      default: t.out = a & ~b;
    endcase
    if (op <= 3'd2) begin
      t.out = r[W-1:0];
      t.co  = (r < 0) || (r >= (1 << W));
      t.ovf = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
    end
    t.z = (t.out == '0);
    t.n = t.out[W-1];
    return t;
  endfunction

  // Called at a falling edge with inputs already driven; checks this cycle and returns at the next falling edge.
  task automatic cycle();
    logic g;
    rsp_t act;
    #1;
    acc0 = req0_ready;
    acc1 = req1_ready;
    act  = {rsp_id, rsp_out, rsp_co, rsp_ovf, rsp_z, rsp_n};
    checks++;
    if (req0_ready && req1_ready) begin
      errors++;
      $display("FAIL both_ready: ready0=%b ready1=%b, at most one allowed", req0_ready, req1_ready);
    end
    case (phase)
      0: begin
        checks++;
        if (rsp_valid !== 1'b0) begin
          errors++;
          $display("FAIL idle_rsp_valid: got %b want 0", rsp_valid);
        end
        if (req0_valid || req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
          g = req0_valid ? 1'b0 : 1'b1;
`else
          if (req0_valid && req1_valid) g = ~last_g;
          else                          g = req0_valid ? 1'b0 : 1'b1;
`endif
          checks++;
          if ({req0_ready, req1_ready} !== (g ? 2'b01 : 2'b10)) begin
            errors++;
            $display("FAIL grant: ready0/1=%b%b want grant to req%0d", req0_ready, req1_ready, g);
          end
          exp_rsp = g ? ref_alu(1'b1, req1_op, req1_a, req1_b)
                      : ref_alu(1'b0, req0_op, req0_a, req0_b);
          last_g  = g;
          grant_log.push_back(g);
          phase   = 1;
        end else begin
          checks++;
          if ({req0_ready, req1_ready} !== 2'b00) begin
            errors++;
            $display("FAIL idle_no_req: ready0/1=%b%b want 00", req0_ready, req1_ready);
          end
        end
      end
      1: begin
        checks++;
        if ({rsp_valid, req0_ready, req1_ready} !== 3'b000) begin
          errors++;
          $display("FAIL exec_ctrl: valid/ready0/ready1=%b%b%b want 000", rsp_valid, req0_ready, req1_ready);
        end
        phase = 2;
      end
      default: begin
        checks++;
        if ({rsp_valid, req0_ready, req1_ready} !== 3'b100) begin
          errors++;
          $display("FAIL resp_ctrl: valid/ready0/ready1=%b%b%b want 100", rsp_valid, req0_ready, req1_ready);
        end
        checks++;
        if (act !== exp_rsp) begin
          errors++;
          $display("FAIL rsp_data: got id=%b out=%h co=%b ovf=%b z=%b n=%b want id=%b out=%h co=%b ovf=%b z=%b n=%b",
                   act.id, act.out, act.co, act.ovf, act.z, act.n,
                   exp_rsp.id, exp_rsp.out, exp_rsp.co, exp_rsp.ovf, exp_rsp.z, exp_rsp.n);
        end
        last_seen = act;
        if (rsp_ready) phase = 0;
      end
    endcase
    @(negedge clk);
  endtask

  task automatic model_reset();
    phase  = 0;
    last_g = 1'b1;
    acc0   = 1'b0;
    acc1   = 1'b0;
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (acc0) req0_valid = 1'b0;
      if (acc1) req1_valid = 1'b0;
      if (phase == 0 && !req0_valid && !req1_valid) begin
        done = 1'b1;
        break;
      end
      cycle();
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain_timeout: pending=%b%b phase=%0d want all served", req0_valid, req1_valid, phase);
    end
  endtask

  task automatic run_op(input logic id, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int stall);
    logic done;
    done = 1'b0;
    rsp_ready = 1'b1;
    if (id) begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
    for (int i = 0; i < 20 && !done; i++) begin
      cycle();
      done = id ? acc1 : acc0;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL accept_timeout: req%0d never accepted, want accept within 20 cycles", id);
    end
    if (id) req1_valid = 1'b0;
    else    req0_valid = 1'b0;
    cycle();
    for (int i = 0; i < stall; i++) begin
      rsp_ready = 1'b0;
      cycle();
    end
    rsp_ready = 1'b1;
    cycle();
  endtask

  task automatic test_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b0;
    rst_n      = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_out, rsp_co, rsp_ovf, rsp_z, rsp_n, req0_ready, req1_ready} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b id=%b out=%h co=%b ovf=%b z=%b n=%b rdy=%b%b want all 0",
               rsp_valid, rsp_id, rsp_out, rsp_co, rsp_ovf, rsp_z, rsp_n, req0_ready, req1_ready);
    end
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    cycle();
  endtask

  task automatic test_spec_vectors();
    run_op(1'b0, OP_ADD, 4'h7, 4'h1, 0);
    checks++;
    if (last_seen !== rsp_t'({1'b0, 4'h8, 1'b0, 1'b1, 1'b0, 1'b1})) begin
      errors++;
      $display("FAIL add_7_1: got %h want %h", last_seen, rsp_t'({1'b0, 4'h8, 1'b0, 1'b1, 1'b0, 1'b1}));
    end
    run_op(1'b1, OP_SUB, 4'h3, 4'h5, 0);
    checks++;
    if (last_seen !== rsp_t'({1'b1, 4'hE, 1'b1, 1'b0, 1'b0, 1'b1})) begin
      errors++;
      $display("FAIL sub_3_5: got %h want %h", last_seen, rsp_t'({1'b1, 4'hE, 1'b1, 1'b0, 1'b0, 1'b1}));
    end
  endtask

  // req1 stays valid the whole time; it must not be readied while req0's response is held.
  task automatic test_hold();
    req1_valid = 1'b1;
    req1_op    = OP_OR;
    req1_a     = 4'h2;
    req1_b     = 4'h4;
    run_op(1'b0, OP_XNOR, 4'h5, 4'h5, 5);
    checks++;
    if (last_seen !== rsp_t'({1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1})) begin
      errors++;
      $display("FAIL xnor_hold: got %h want %h", last_seen, rsp_t'({1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1}));
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic       ids[4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0] ops[4]  = '{OP_ADD, OP_SUB, OP_RSUB, OP_ANDN};
    logic [3:0] as[4]   = '{4'hF, 4'h8, 4'h2, 4'hF};
    logic [3:0] bs[4]   = '{4'h1, 4'h1, 4'h1, 4'h5};
    rsp_t       want[4] = '{rsp_t'(9'b0_0000_1010), rsp_t'(9'b1_0111_0100),
                            rsp_t'(9'b0_1111_1001), rsp_t'(9'b1_1010_0001)};
    for (int k = 0; k < 4; k++) begin
      run_op(ids[k], ops[k], as[k], bs[k], 0);
      checks++;
      if (last_seen !== want[k]) begin
        errors++;
        $display("FAIL b2b_%0d: got %h want %h", k, last_seen, want[k]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic want[4];
`ifdef ALU_ARB_FIXED_PRIO_EN
    logic done;
    want = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    want = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    test_reset();
    grant_log.delete();
    rsp_ready  = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_op = 3'($urandom); req0_a = W'($urandom); req0_b = W'($urandom);
    req1_op = 3'($urandom); req1_a = W'($urandom); req1_b = W'($urandom);
    for (int i = 0; i < 60 && grant_log.size() < 4; i++) begin
      if (acc0) begin req0_op = 3'($urandom); req0_a = W'($urandom); req0_b = W'($urandom); end
      if (acc1) begin req1_op = 3'($urandom); req1_a = W'($urandom); req1_b = W'($urandom); end
      cycle();
    end
    checks++;
    if (grant_log.size() != 4) begin
      errors++;
      $display("FAIL rr_count: got %0d grants want 4", grant_log.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (grant_log[k] !== want[k]) begin
          errors++;
          $display("FAIL rr_order_%0d: got req%0d want req%0d", k, grant_log[k], want[k]);
        end
      end
    end
`ifdef ALU_ARB_FIXED_PRIO_EN
    req0_valid = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      cycle();
      done = acc1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL fixed_req1_served: req1 not accepted after req0 idle, want accept");
    end
`endif
    drain();
  endtask

  task automatic test_reset_mid();
    logic done;
    for (int depth = 1; depth <= 2; depth++) begin
      rsp_ready  = 1'b0;
      req0_valid = 1'b1;
      req0_op    = OP_ADD;
      req0_a     = 4'h3;
      req0_b     = 4'h4;
      done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
        cycle();
        done = acc0;
      end
      req0_valid = 1'b0;
      if (depth == 2) cycle();
      rst_n = 1'b0;
      #1;
      checks++;
      if ({rsp_valid, rsp_id, rsp_out, rsp_co, rsp_ovf, rsp_z, rsp_n, req0_ready, req1_ready} !== '0) begin
        errors++;
        $display("FAIL reset_mid_%0d: valid=%b id=%b out=%h co=%b ovf=%b z=%b n=%b want all 0",
                 depth, rsp_valid, rsp_id, rsp_out, rsp_co, rsp_ovf, rsp_z, rsp_n);
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      run_op(1'b0, OP_ADD, 4'h3, 4'h4, 0);
      checks++;
      if (last_seen !== rsp_t'({1'b0, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0})) begin
        errors++;
        $display("FAIL reissue_%0d: got %h want %h", depth, last_seen, rsp_t'({1'b0, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0}));
      end
    end
  endtask

  task automatic test_random(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      if (acc0 || !req0_valid) begin
        req0_valid = ($urandom_range(0, 1) == 1);
        req0_op = 3'($urandom); req0_a = W'($urandom); req0_b = W'($urandom);
      end
      if (acc1 || !req1_valid) begin
        req1_valid = ($urandom_range(0, 1) == 1);
        req1_op = 3'($urandom); req1_a = W'($urandom); req1_b = W'($urandom);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_spec_vectors();
    test_hold();
    test_back_to_back();
    test_round_robin();
    test_reset_mid();
    test_random(400);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
